// File: rtl/z_test.sv
// z_test: per-fragment depth test between the rasterizer and the pixel path.
//
// Each accepted fragment (x, y, z, color) is turned into a linear address
// y*320 + x. The stored depth for that address is read from an external
// synchronous z buffer, which has one cycle of read latency. The fragment
// passes when its z is strictly nearer, that is smaller, than the stored
// depth. A passing fragment writes its z back and is forwarded downstream.
// Pixels outside the screen are accepted and dropped. A clear request
// drains the pipeline and then writes CLEAR_Z to every z buffer entry.
//
// Ports:
//   clk, rst_n                     clock and asynchronous active-low reset
//   in_valid/in_ready              fragment handshake
//   in_x/in_y/in_z/in_color        fragment fields
//   out_valid/out_ready            passing-fragment handshake
//   out_addr/out_color             linear pixel address and colour
//   zb_r_addr/zb_r_data            z buffer read port (data one cycle later)
//   zb_w_en/zb_w_addr/zb_w_data    z buffer write port
//   clear_start                    single-cycle clear request
//   busy                           clear pending or in progress
//   clear_done                     one-cycle pulse when the clear completes
module z_test #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int Z_W     = 6,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8:0]         in_x,
  input  logic [7:0]         in_y,
  input  logic [Z_W-1:0]     in_z,
  input  logic [COLOR_W-1:0] in_color,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [16:0]        out_addr,
  output logic [COLOR_W-1:0] out_color,
  output logic [16:0]        zb_r_addr,
  input  logic [Z_W-1:0]     zb_r_data,
  output logic               zb_w_en,
  output logic [16:0]        zb_w_addr,
  output logic [Z_W-1:0]     zb_w_data,
  input  logic               clear_start,
  output logic               busy,
  output logic               clear_done
);

  localparam logic [Z_W-1:0] CLEAR_Z   = {Z_W{1'b1}};
  localparam logic [8:0]     H_LIM     = 9'(H_RES);
  localparam logic [7:0]     V_LIM     = 8'(V_RES);
  localparam logic [16:0]    LAST_ADDR = 17'(H_RES * V_RES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [16:0]          cnt_r;
  logic                 alive_r;
  logic                 done_r;
  logic                 s1_valid_r;
  logic [16:0]          s1_addr_r;
  logic [Z_W-1:0]       s1_z_r;
  logic [COLOR_W-1:0]   s1_color_r;
  logic                 s2_valid_r;
  logic [16:0]          s2_addr_r;
  logic [COLOR_W-1:0]   s2_color_r;
  logic                 fwd_valid_r;
  logic [16:0]          fwd_addr_r;
  logic [Z_W-1:0]       fwd_data_r;

  logic                 advance_s;
  logic                 accept_s;
  logic                 in_range_s;
  logic [16:0]          in_addr_s;
  logic [Z_W-1:0]       eff_z_s;
  logic                 fire_s;
  logic                 pass_s;

  // y*320 + x as shifts; the address fits in 17 bits even for off-screen x/y
  assign in_addr_s  = ({9'd0, in_y} << 8) + ({9'd0, in_y} << 6) + {8'd0, in_x};
  assign in_range_s = (in_x < H_LIM) && (in_y < V_LIM);
  assign advance_s  = !s2_valid_r || out_ready;
  // alive_r keeps in_ready low during reset; a same-cycle clear request wins
  assign in_ready   = alive_r && (state_r == RUN) && !clear_start &&
                      (!s1_valid_r || advance_s);
  assign accept_s   = in_valid && in_ready;
  // A stalled S1 keeps re-reading its own address so its data stays fresh
  assign zb_r_addr  = in_ready ? in_addr_s : s1_addr_r;
  // The buffer does not yet show last cycle's write, so forward it instead
  assign eff_z_s    = (fwd_valid_r && (fwd_addr_r == s1_addr_r)) ? fwd_data_r : zb_r_data;
  assign pass_s     = (s1_z_r < eff_z_s);
  assign fire_s     = s1_valid_r && advance_s;

  assign out_valid  = s2_valid_r;
  assign out_addr   = s2_addr_r;
  assign out_color  = s2_color_r;
  assign busy       = (state_r != RUN);
  assign clear_done = done_r;

  // Next-state and z buffer write port
  always_comb begin
    state_s   = state_r;
    zb_w_en   = 1'b0;
    zb_w_addr = 17'd0;
    zb_w_data = {Z_W{1'b0}};
    if (fire_s && pass_s) begin
      zb_w_en   = 1'b1;
      zb_w_addr = s1_addr_r;
      zb_w_data = s1_z_r;
    end else begin
      zb_w_en   = 1'b0;
    end
    case (state_r)
      RUN: begin
        if (clear_start) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (!s1_valid_r && !s2_valid_r) begin
          state_s = CLEAR;
        end else begin
          state_s = DRAIN;
        end
      end
      CLEAR: begin
        zb_w_en   = 1'b1;
        zb_w_addr = cnt_r;
        zb_w_data = CLEAR_Z;
        if (cnt_r == LAST_ADDR) begin
          state_s = RUN;
        end else begin
          state_s = CLEAR;
        end
      end
      default: begin
        state_s = RUN;
      end
    endcase
  end

  // Control state, clear counter and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      cnt_r   <= 17'd0;
      alive_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      alive_r <= 1'b1;
      done_r  <= (state_r == CLEAR) && (cnt_r == LAST_ADDR);
      if (state_r == CLEAR) begin
        cnt_r <= cnt_r + 17'd1;
      end else begin
        cnt_r <= 17'd0;
      end
    end
  end

  // S1: fragment waiting for its stored depth; off-screen pixels never load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= 17'd0;
      s1_z_r     <= {Z_W{1'b0}};
      s1_color_r <= {COLOR_W{1'b0}};
    end else if (!s1_valid_r || advance_s) begin
      s1_valid_r <= accept_s && in_range_s;
      if (accept_s) begin
        s1_addr_r  <= in_addr_s;
        s1_z_r     <= in_z;
        s1_color_r <= in_color;
      end
    end
  end

  // S2: output register, held while the downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_addr_r  <= 17'd0;
      s2_color_r <= {COLOR_W{1'b0}};
    end else if (advance_s) begin
      s2_valid_r <= fire_s && pass_s;
      if (fire_s && pass_s) begin
        s2_addr_r  <= s1_addr_r;
        s2_color_r <= s1_color_r;
      end
    end
  end

  // Forwarding record of last cycle's fragment write; clear writes never enter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_r <= 1'b0;
      fwd_addr_r  <= 17'd0;
      fwd_data_r  <= {Z_W{1'b0}};
    end else begin
      fwd_valid_r <= zb_w_en && (state_r != CLEAR);
      fwd_addr_r  <= zb_w_addr;
      fwd_data_r  <= zb_w_data;
    end
  end

endmodule

// File: tb/tb_z_test.sv
// Directed testbench for z_test with a behavioural z buffer memory.
module tb_z_test;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_x = 9'd0;
  logic [7:0]  in_y = 8'd0;
  logic [5:0]  in_z = 6'd0;
  logic [7:0]  in_color = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] out_addr;
  logic [7:0]  out_color;
  logic [16:0] zb_r_addr;
  logic [5:0]  zb_r_data = 6'd0;
  logic        zb_w_en;
  logic [16:0] zb_w_addr;
  logic [5:0]  zb_w_data;
  logic        clear_start = 1'b0;
  logic        busy;
  logic        clear_done;

  z_test dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_color(in_color),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_color(out_color),
    .zb_r_addr(zb_r_addr), .zb_r_data(zb_r_data),
    .zb_w_en(zb_w_en), .zb_w_addr(zb_w_addr), .zb_w_data(zb_w_data),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  // z buffer: synchronous read, a write becomes visible to reads issued next cycle
  logic [5:0] mem [0:76799];
  always @(posedge clk) begin
    zb_r_data <= (zb_r_addr < 17'd76800) ? mem[zb_r_addr] : 6'd0;
    if (zb_w_en && (zb_w_addr < 17'd76800)) mem[zb_w_addr] <= zb_w_data;
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic [16:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t  wq[$];
  ev_t  oq[$];
  int   cyc = 0;
  int   clr_cnt = 0;
  int   clr_next = 0;
  int   clr_bad = 0;
  int   done_cnt = 0;
  int   acc_cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: clear writes (data 3F) checked for sequence, others logged
  always @(negedge clk) begin
    if (rst_n) begin
      if (zb_w_en) begin
        if (zb_w_data == 6'h3F) begin
          if (int'(zb_w_addr) != clr_next) clr_bad = clr_bad + 1;
          clr_next = clr_next + 1;
          clr_cnt  = clr_cnt + 1;
        end else begin
          wq.push_back('{cyc: cyc, addr: zb_w_addr, data: {2'b00, zb_w_data}});
        end
      end
      if (out_valid && out_ready)
        oq.push_back('{cyc: cyc, addr: out_addr, data: out_color});
      if (clear_done) done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input int i, input logic [16:0] a, input logic [5:0] d);
    if (i < wq.size()) begin
      check({tag, " waddr"}, 32'(wq[i].addr), 32'(a));
      check({tag, " wdata"}, 32'(wq[i].data), 32'(d));
    end else begin
      check({tag, " wcount"}, wq.size(), i + 1);
    end
  endtask

  task automatic chk_o(input string tag, input int i, input logic [16:0] a, input logic [7:0] c);
    if (i < oq.size()) begin
      check({tag, " oaddr"}, 32'(oq[i].addr), 32'(a));
      check({tag, " ocolor"}, 32'(oq[i].data), 32'(c));
    end else begin
      check({tag, " ocount"}, oq.size(), i + 1);
    end
  endtask

  // Present one fragment, wait (bounded) for acceptance, then drop in_valid
  task automatic drive(input logic [8:0] x, input logic [7:0] y, input logic [5:0] z,
                       input logic [7:0] c, input string tag);
    int got;
    got = 0;
    in_x = x; in_y = y; in_z = z; in_color = c; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        acc_cyc = cyc;
        break;
      end
    end
    check({tag, " accepted"}, got, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int got;
    // ---- reset values ----
    #12;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_addr", out_addr, 0);
    check("rst out_color", out_color, 0);
    check("rst zb_w_en", zb_w_en, 0);
    check("rst zb_w_addr", zb_w_addr, 0);
    check("rst zb_w_data", zb_w_data, 0);
    check("rst busy", busy, 0);
    check("rst clear_done", clear_done, 0);
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    check("run in_ready", in_ready, 1);

    // ---- full clear; clear_start beats a simultaneous fragment ----
    clr_cnt = 0; clr_next = 0;
    clear_start = 1'b1;
    in_x = 9'd10; in_y = 8'd2; in_z = 6'd1; in_color = 8'h11; in_valid = 1'b1;
    @(negedge clk);
    check("clear wins in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear_start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clear busy", busy, 1);
    got = 0;
    for (int i = 0; i < 80000; i++) begin
      @(negedge clk); #1;
      if (clear_done) begin
        got = 1;
        break;
      end
    end
    check("clear_done seen", got, 1);
    check("clear write count", clr_cnt, 76800);
    check("clear write order", clr_bad, 0);
    check("busy after clear", busy, 0);
    check("no fragment writes", wq.size(), 0);
    @(negedge clk);
    check("clear_done one cycle", clear_done, 0);
    @(posedge clk); #1;

    // ---- first fragment, latency ----
    wq.delete(); oq.delete();
    drive(9'd10, 8'd2, 6'd20, 8'h5A, "frag650");
    idle(4);
    check("frag650 writes", wq.size(), 1);
    chk_w("frag650", 0, 17'd650, 6'd20);
    check("frag650 outs", oq.size(), 1);
    chk_o("frag650", 0, 17'd650, 8'h5A);
    if (wq.size() > 0) check("write latency", wq[0].cyc, acc_cyc + 1);
    if (oq.size() > 0) check("out latency", oq[0].cyc, acc_cyc + 2);

    // ---- occlusion and equality, back-to-back at pixel (5,5) ----
    wq.delete(); oq.delete();
    drive(9'd5, 8'd5, 6'd20, 8'hB1, "occ1");
    drive(9'd5, 8'd5, 6'd30, 8'hB2, "occ2");
    drive(9'd5, 8'd5, 6'd20, 8'hB3, "occ3");
    idle(4);
    check("occ writes", wq.size(), 1);
    chk_w("occ", 0, 17'd1605, 6'd20);
    check("occ outs", oq.size(), 1);
    chk_o("occ", 0, 17'd1605, 8'hB1);

    // ---- forwarding at (0,0): 40 pass, 35 pass, 36 fail ----
    wq.delete(); oq.delete();
    drive(9'd0, 8'd0, 6'd40, 8'hC0, "fwd40");
    drive(9'd0, 8'd0, 6'd35, 8'hC1, "fwd35");
    drive(9'd0, 8'd0, 6'd36, 8'hC2, "fwd36");
    idle(4);
    check("fwd writes", wq.size(), 2);
    chk_w("fwd a", 0, 17'd0, 6'd40);
    chk_w("fwd b", 1, 17'd0, 6'd35);
    check("fwd outs", oq.size(), 2);
    chk_o("fwd b", 1, 17'd0, 8'hC1);
    check("fwd final depth", mem[0], 35);

    // ---- backpressure: out_ready low for 5 cycles ----
    wq.delete(); oq.delete();
    out_ready = 1'b0;
    drive(9'd1, 8'd1, 6'd10, 8'hA1, "bp1");
    drive(9'd2, 8'd1, 6'd11, 8'hA2, "bp2");
    in_x = 9'd3; in_y = 8'd1; in_z = 6'd12; in_color = 8'hA3; in_valid = 1'b1;
    @(negedge clk);
    check("bp in_ready low", in_ready, 0);
    check("bp out_valid", out_valid, 1);
    @(negedge clk);
    check("bp out_addr held", out_addr, 321);
    check("bp in_ready still low", in_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("bp writes while stalled", wq.size(), 1);
    out_ready = 1'b1;
    drive(9'd3, 8'd1, 6'd12, 8'hA3, "bp3");
    idle(4);
    check("bp writes", wq.size(), 3);
    chk_w("bp1", 0, 17'd321, 6'd10);
    chk_w("bp2", 1, 17'd322, 6'd11);
    chk_w("bp3", 2, 17'd323, 6'd12);
    check("bp outs", oq.size(), 3);
    chk_o("bp1", 0, 17'd321, 8'hA1);
    chk_o("bp2", 1, 17'd322, 8'hA2);
    chk_o("bp3", 2, 17'd323, 8'hA3);

    // ---- out of range dropped; last on-screen pixel passes ----
    wq.delete(); oq.delete();
    drive(9'd320, 8'd0, 6'd5, 8'hD0, "x320");
    drive(9'd0, 8'd240, 6'd5, 8'hD1, "y240");
    idle(4);
    check("oor writes", wq.size(), 0);
    check("oor outs", oq.size(), 0);
    drive(9'd319, 8'd239, 6'd1, 8'hEE, "last pixel");
    idle(4);
    chk_w("last pixel", 0, 17'd76799, 6'd1);
    chk_o("last pixel", 0, 17'd76799, 8'hEE);

    // ---- clear with S2 stalled, then reset mid-clear ----
    wq.delete(); oq.delete();
    clr_cnt = 0; clr_next = 0;
    out_ready = 1'b0;
    drive(9'd7, 8'd0, 6'd9, 8'h77, "stall frag");
    clear_start = 1'b1;
    @(negedge clk);
    check("clr2 in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear_start = 1'b0;
    idle(3);
    check("drain busy", busy, 1);
    check("drain in_ready", in_ready, 0);
    check("drain out_valid", out_valid, 1);
    check("drain no clear writes", clr_cnt, 0);
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (clr_cnt >= 1000) begin
        got = 1;
        break;
      end
    end
    check("clear reached 1000", got, 1);
    rst_n = 1'b0;
    #1;
    check("abort in_ready", in_ready, 0);
    check("abort out_valid", out_valid, 0);
    check("abort out_addr", out_addr, 0);
    check("abort out_color", out_color, 0);
    check("abort zb_w_en", zb_w_en, 0);
    check("abort zb_w_addr", zb_w_addr, 0);
    check("abort zb_w_data", zb_w_data, 0);
    check("abort busy", busy, 0);
    check("abort clear_done", clear_done, 0);
    @(negedge clk); rst_n = 1'b1;
    idle(3);
    check("post reset in_ready", in_ready, 1);
    check("post reset busy", busy, 0);
    chk_w("stall frag", 0, 17'd7, 6'd9);
    chk_o("stall frag", 0, 17'd7, 8'h77);
    check("no extra clear_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
